// File: rtl/gpu_fill_ctrl.sv
// MMIO-programmed rectangle fill/clear sequencer: turns a CPU-written rectangle into
// one clipped framebuffer pixel write per granted cycle, with busy/done/error status.
module gpu_fill_ctrl #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int XY_W    = 9,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mmio_we,
    input  logic [2:0]         mmio_addr,
    input  logic [31:0]        mmio_wdata,
    output logic [31:0]        mmio_rdata,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_gnt,
    output logic               busy,
    output logic               irq
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    localparam logic [XY_W-1:0]   FB_W_XY = XY_W'(FB_W);
    localparam logic [XY_W-1:0]   FB_H_XY = XY_W'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);

    state_t              state_reg, state_next;
    logic [3:0][XY_W-1:0] xy_val;          // 0:X0 1:Y0 2:W 3:H
    logic [COLOR_W-1:0]  color_reg;
    logic                clear_reg, done_reg, error_reg;
    logic [XY_W-1:0]     col_reg, row_reg, w_eff_reg, h_eff_reg;
    logic [ADDR_W-1:0]   row_base_reg;

    logic idle, ctrl_we, start_fill, start_clear, start, irq_ack;
    logic rect_bad, last_col, last_row, grant, finish_draw;
    logic [XY_W-1:0]   room_x, room_y, w_clip, h_clip;
    logic [ADDR_W-1:0] base_setup;

    assign idle        = (state_reg == S_IDLE);
    assign ctrl_we     = mmio_we && (mmio_addr == 3'd5);
    assign start_fill  = ctrl_we && idle && mmio_wdata[0];
    assign start_clear = ctrl_we && idle && mmio_wdata[1];
    assign start       = start_fill || start_clear;
    assign irq_ack     = ctrl_we && mmio_wdata[2];

    // Geometry registers are frozen while a command is running.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_xy
            logic [XY_W-1:0] val_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    val_reg <= '0;
                else if (mmio_we && idle && mmio_addr == 3'(gi))
                    val_reg <= mmio_wdata[XY_W-1:0];
            end
            assign xy_val[gi] = val_reg;
        end
    endgenerate

    // CLEAR ignores the programmed rectangle and covers the whole screen.
    assign rect_bad   = !clear_reg && (xy_val[0] >= FB_W_XY || xy_val[1] >= FB_H_XY ||
                                       xy_val[2] == '0 || xy_val[3] == '0);
    assign room_x     = FB_W_XY - xy_val[0];
    assign room_y     = FB_H_XY - xy_val[1];
    assign w_clip     = clear_reg ? FB_W_XY : ((xy_val[2] < room_x) ? xy_val[2] : room_x);
    assign h_clip     = clear_reg ? FB_H_XY : ((xy_val[3] < room_y) ? xy_val[3] : room_y);
    assign base_setup = clear_reg ? '0 : ADDR_W'(xy_val[1]) * FB_W_A + ADDR_W'(xy_val[0]);

    assign last_col    = (col_reg == w_eff_reg - XY_W'(1));
    assign last_row    = (row_reg == h_eff_reg - XY_W'(1));
    assign grant       = (state_reg == S_DRAW) && fb_gnt;
    assign finish_draw = grant && last_col && last_row;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fb_req     = 1'b0;
        fb_addr    = '0;
        fb_data    = '0;
        busy       = !idle;
        irq        = done_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: state_next = rect_bad ? S_IDLE : S_DRAW;
            S_DRAW: begin
                fb_req  = 1'b1;
                fb_addr = row_base_reg + ADDR_W'(col_reg);
                fb_data = color_reg;
                if (finish_draw) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_reg    <= '0;
            clear_reg    <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            col_reg      <= '0;
            row_reg      <= '0;
            w_eff_reg    <= '0;
            h_eff_reg    <= '0;
            row_base_reg <= '0;
        end else begin
            if (mmio_we && idle && mmio_addr == 3'd4)
                color_reg <= mmio_wdata[COLOR_W-1:0];

            if (start) begin
                done_reg  <= 1'b0;
                error_reg <= 1'b0;
                clear_reg <= start_clear;
            end else if (irq_ack) begin
                done_reg <= 1'b0;
            end

            if (state_reg == S_SETUP) begin
                col_reg      <= '0;
                row_reg      <= '0;
                w_eff_reg    <= w_clip;
                h_eff_reg    <= h_clip;
                row_base_reg <= base_setup;
                if (rect_bad) begin
                    done_reg  <= 1'b1;
                    error_reg <= 1'b1;
                end
            end

            if (grant) begin
                if (last_col) begin
                    col_reg      <= '0;
                    row_reg      <= row_reg + XY_W'(1);
                    row_base_reg <= row_base_reg + FB_W_A;
                end else begin
                    col_reg <= col_reg + XY_W'(1);
                end
            end

            // Completion is written last so it beats a coincident IRQ_ACK.
            if (finish_draw)
                done_reg <= 1'b1;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_addr)
            3'd0, 3'd1, 3'd2, 3'd3: mmio_rdata[XY_W-1:0] = xy_val[mmio_addr[1:0]];
            3'd4:                   mmio_rdata[COLOR_W-1:0] = color_reg;
            3'd6:                   mmio_rdata[2:0] = {error_reg, done_reg, busy};
            default:                mmio_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpu_fill_ctrl.sv
// Bench for gpu_fill_ctrl: vector table, hand-written timing sequences and randomized
// rectangles checked against a loop-based model of the clipped pixel list.
`timescale 1ns/1ps
module tb_gpu_fill_ctrl;
    localparam int FB_W = 320;
    localparam int FB_H = 240;
    localparam int NPIX = FB_W * FB_H;

    logic        clk = 1'b0;
    logic        rst, mmio_we, fb_req, fb_gnt, busy, irq;
    logic [2:0]  mmio_addr;
    logic [31:0] mmio_wdata, mmio_rdata;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;

    gpu_fill_ctrl dut (
        .clk(clk), .rst(rst), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .fb_req(fb_req),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_gnt(fb_gnt), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int got_addr[$];
    int got_data[$];
    int exp_q[$];

    typedef struct {
        int x0, y0, w, h, color, ctrl;
        int cnt, first, last, status;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs seen at the falling edge are what the next rising edge samples.
    always @(negedge clk) begin
        if (!rst && fb_req && fb_gnt) begin
            got_addr.push_back(int'(fb_addr));
            got_data.push_back(int'(fb_data));
            check("addr_in_fb", int'(fb_addr <= 17'(NPIX - 1)), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        mmio_we    = 1'b1;
        mmio_addr  = 3'(addr);
        mmio_wdata = 32'(data);
        step();
        mmio_we    = 1'b0;
        mmio_wdata = '0;
    endtask

    task automatic rd(input int addr, output int v);
        mmio_addr = 3'(addr);
        #0.2;
        v = int'(mmio_rdata);
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int color);
        wr(0, x0); wr(1, y0); wr(2, w); wr(3, h); wr(4, color);
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic run_cmd(input int gnt_pct, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            fb_gnt = ($urandom_range(0, 99) < gnt_pct);
            step();
            n++;
        end
        fb_gnt = 1'b0;
        check("cmd_timeout_busy", int'(busy), 0);
    endtask

    // Expected pixel list: every on-screen point of the rectangle, row-major.
    task automatic build_model(input int x0, input int y0, input int w, input int h, input bit clr);
        exp_q.delete();
        if (clr) begin
            x0 = 0; y0 = 0; w = FB_W; h = FB_H;
        end
        if (x0 >= FB_W || y0 >= FB_H || w == 0 || h == 0) return;
        for (int y = y0; y < y0 + h && y < FB_H; y++)
            for (int x = x0; x < x0 + w && x < FB_W; x++)
                exp_q.push_back(y * FB_W + x);
    endtask

    task automatic compare_model(input string name, input int color);
        int errs = 0;
        int n;
        check({name, "_count"}, got_addr.size(), exp_q.size());
        n = (got_addr.size() < exp_q.size()) ? got_addr.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_addr[i] != exp_q[i] || got_data[i] != color) errs++;
        check({name, "_seq_errs"}, errs, 0);
    endtask

    initial begin
        int v;
        int basic_exp[4];
        rst = 1'b1; mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0; fb_gnt = 1'b0;
        basic_exp = '{321, 322, 641, 642};

        vecs[0] = '{1,   1,   2,   2, 'hA5, 1, 4, 321,   642,   2};
        vecs[1] = '{318, 239, 10,  5, 'h3C, 1, 2, 76798, 76799, 2};
        vecs[2] = '{5,   5,   0,   3, 'h77, 1, 0, 0,     0,     6};
        vecs[3] = '{320, 0,   4,   4, 'h77, 1, 0, 0,     0,     6};
        vecs[4] = '{0,   240, 1,   1, 'h11, 1, 0, 0,     0,     6};
        vecs[5] = '{7,   7,   3,   0, 'h22, 1, 0, 0,     0,     6};
        vecs[6] = '{319, 239, 1,   1, 'hFF, 1, 1, 76799, 76799, 2};
        vecs[7] = '{300, 10,  511, 1, 'hC3, 5, 20, 3500, 3519,  2};

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        check("rst_fb_req", int'(fb_req), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_irq", int'(irq), 0);
        for (int a = 0; a < 8; a++) begin
            rd(a, v);
            check($sformatf("rst_reg%0d", a), v, 0);
        end

        // Register masking and write-only/unused addresses
        wr(0, 32'hFFFF_FFFF); rd(0, v); check("x0_mask", v, 'h1FF);
        wr(4, 32'hFFFF_FF5A); rd(4, v); check("color_mask", v, 'h5A);
        wr(7, 32'hFFFF_FFFF); rd(7, v); check("reg7_zero", v, 0);
        wr(5, 0);             rd(5, v); check("ctrl_reads0", v, 0);

        // Table-driven fills
        for (int i = 0; i < 8; i++) begin
            program_rect(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color);
            wr(5, vecs[i].ctrl);
            run_cmd(100, 1000);
            rd(6, v);
            check($sformatf("vec%0d_status", i), v, vecs[i].status);
            check($sformatf("vec%0d_irq", i), int'(irq), 1);
            check($sformatf("vec%0d_count", i), got_addr.size(), vecs[i].cnt);
            if (vecs[i].cnt > 0) begin
                check($sformatf("vec%0d_first", i), got_addr[0], vecs[i].first);
                check($sformatf("vec%0d_last", i), got_addr[got_addr.size() - 1], vecs[i].last);
            end
            build_model(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, 1'b0);
            compare_model($sformatf("vec%0d_model", i), vecs[i].color);
        end

        // Basic fill, cycle by cycle
        program_rect(1, 1, 2, 2, 'hA5);
        fb_gnt = 1'b1;
        wr(5, 1);
        check("basic_setup_req", int'(fb_req), 0);
        check("basic_setup_busy", int'(busy), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_req%0d", i), int'(fb_req), 1);
            check($sformatf("basic_addr%0d", i), int'(fb_addr), basic_exp[i]);
            check($sformatf("basic_data%0d", i), int'(fb_data), 'hA5);
            step();
        end
        fb_gnt = 1'b0;
        check("basic_busy_fall", int'(busy), 0);
        check("basic_req_fall", int'(fb_req), 0);
        check("basic_irq", int'(irq), 1);
        rd(6, v); check("basic_status", v, 2);

        // Backpressure on pixel 1
        program_rect(0, 0, 3, 1, 'h3C);
        fb_gnt = 1'b1;
        wr(5, 1);
        step();
        check("bp_addr0", int'(fb_addr), 0);
        step();
        fb_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_req%0d", i), int'(fb_req), 1);
            check($sformatf("bp_hold_addr%0d", i), int'(fb_addr), 1);
            check($sformatf("bp_hold_data%0d", i), int'(fb_data), 'h3C);
            step();
        end
        run_cmd(100, 20);
        build_model(0, 0, 3, 1, 1'b0);
        compare_model("bp_model", 'h3C);

        // IRQ_ACK coinciding with completion, then a later ACK
        program_rect(5, 5, 1, 1, 'h11);
        fb_gnt = 1'b1;
        wr(5, 1);
        step();
        wr(5, 4);
        fb_gnt = 1'b0;
        check("ack_completion_irq", int'(irq), 1);
        check("ack_completion_busy", int'(busy), 0);
        wr(5, 4);
        check("ack_later_irq", int'(irq), 0);
        rd(6, v); check("ack_later_status", v, 0);

        // Randomized rectangles, random grant pattern
        for (int it = 0; it < 20; it++) begin
            int x0, y0, w, h, col;
            x0  = ($urandom_range(0, 3) == 0) ? $urandom_range(310, 340) : $urandom_range(0, 319);
            y0  = ($urandom_range(0, 3) == 0) ? $urandom_range(230, 250) : $urandom_range(0, 239);
            w   = ($urandom_range(0, 7) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 12);
            h   = $urandom_range(0, 6);
            col = $urandom_range(0, 255);
            program_rect(x0, y0, w, h, col);
            wr(5, 1);
            run_cmd(75, 5000);
            build_model(x0, y0, w, h, 1'b0);
            compare_model($sformatf("rnd%0d", it), col);
            rd(6, v);
            check($sformatf("rnd%0d_status", it), v, (exp_q.size() == 0) ? 6 : 2);
            check($sformatf("rnd%0d_irq", it), int'(irq), 1);
        end

        // Reset in the middle of a 4x4 fill
        program_rect(2, 3, 4, 4, 'h5A);
        fb_gnt = 1'b1;
        wr(5, 1);
        begin
            int n = 0;
            while (got_addr.size() < 5 && n < 40) begin
                step();
                n++;
            end
        end
        check("mid_rst_grants", got_addr.size(), 5);
        rst = 1'b1;
        fb_gnt = 1'b0;
        step();
        check("mid_rst_req", int'(fb_req), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_irq", int'(irq), 0);
        check("mid_rst_addr", int'(fb_addr), 0);
        for (int a = 0; a < 8; a++) begin
            rd(a, v);
            check($sformatf("mid_rst_reg%0d", a), v, 0);
        end
        rst = 1'b0;
        fb_gnt = 1'b1;
        repeat (10) step();
        fb_gnt = 1'b0;
        check("mid_rst_no_more_writes", got_addr.size(), 5);

        // Full clear with CLEAR+FILL, geometry and start writes ignored mid-command
        program_rect(7, 0, 0, 0, 'h00);
        fb_gnt = 1'b1;
        wr(5, 3);
        wr(0, 100);
        wr(5, 1);
        run_cmd(100, 80000);
        build_model(0, 0, 0, 0, 1'b1);
        compare_model("clear", 0);
        rd(0, v); check("clear_x0_unchanged", v, 7);
        rd(6, v); check("clear_status", v, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_fill_ctrl.md
Name: gpu_fill_ctrl

Overview:
- MMIO-programmed command sequencer for the GPU framebuffer.
- The CPU writes a rectangle (X0, Y0, W, H, COLOR) and a start command. The block then issues one framebuffer pixel write per granted cycle, clipped to the screen, and signals completion via status/IRQ.
- Sits between the MMIO decode (CPU side) and the framebuffer write-port arbiter (GPU side).

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- XY_W, 9, width of coordinate/size registers.
- ADDR_W, 17, framebuffer word address width (FB_W*FB_H <= 2^ADDR_W).
- COLOR_W, 8, pixel width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mmio_we  in  1  register write strobe (single cycle).
- mmio_addr  in  3  register word index.
- mmio_wdata  in  32  write data.
- mmio_rdata  out  32  read data, combinational from mmio_addr.
- fb_req  out  1  pixel write request.
- fb_addr  out  ADDR_W  pixel address = y*FB_W + x.
- fb_data  out  COLOR_W  pixel value.
- fb_gnt  in  1  arbiter grant; write accepted when fb_req && fb_gnt at a rising edge.
- busy  out  1  high while a command is in SETUP/DRAW.
- irq  out  1  level interrupt = done flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Registers (mmio_addr):
  - 0 X0, 1 Y0, 2 W, 3 H: each XY_W bits, from wdata[XY_W-1:0].
  - 4 COLOR: wdata[COLOR_W-1:0].
  - 5 CTRL, write-only, reads 0: bit0 START_FILL, bit1 START_CLEAR, bit2 IRQ_ACK.
  - 6 STATUS, read-only: bit0 busy, bit1 done, bit2 error.
  - 7: reads 0, writes ignored.
  - Unused read bits are 0.
- Reset: all registers 0; state IDLE; fb_req=0, fb_addr=0, fb_data=0, busy=0, irq=0, mmio_rdata reflects zeroed regs. Reset mid-command aborts with no further fb_req from the next cycle; done and error are cleared.
- While busy: writes to regs 0-4 and START bits are ignored. IRQ_ACK is still honoured.
- START_CLEAR and START_FILL in the same write: CLEAR wins.
- START (either kind) clears done and error.
- FSM:
  - IDLE: on START_FILL or START_CLEAR write, go to SETUP.
  - SETUP: 1 cycle.
    - CLEAR: x0=y0=0, w=FB_W, h=FB_H.
    - FILL: latches the rectangle. If X0>=FB_W, Y0>=FB_H, W==0 or H==0, set error and done and return to IDLE with no fb_req.
    - Otherwise compute clipped w_eff=min(W, FB_W-X0), h_eff=min(H, FB_H-Y0), row_base=Y0*FB_W+X0 (multiply only here, or incremental), then go to DRAW.
  - DRAW: fb_req=1.
    - fb_addr = row_base + col; fb_data = latched color (CLEAR uses COLOR too).
    - Outputs hold stable until granted.
    - On grant: col++. If col==w_eff-1, then col=0, row++, row_base+=FB_W. If that was also the last row, deassert fb_req next cycle, set done, go to IDLE.
- Latency: START write in cycle N, SETUP in N+1, first fb_req in N+2. Throughput is 1 pixel/cycle with fb_gnt constantly high. Total pixels = w_eff*h_eff.
- busy=1 in SETUP and DRAW; it falls the cycle after the last grant, the same cycle done rises.
- irq = done.
- IRQ_ACK clears done. If IRQ_ACK coincides with completion, completion wins and done stays 1.
- No writes outside the framebuffer; fb_addr never exceeds FB_W*FB_H-1.

Test Plan:
- Basic fill: X0=1,Y0=1,W=2,H=2,COLOR=0xA5, START_FILL, fb_gnt=1 -> fb_req first high 2 cycles after start; addrs 321,322,641,642, data 0xA5; busy falls after 4th grant; STATUS=0b010; irq=1.
- Clip: X0=318,Y0=239,W=10,H=5 -> exactly 2 writes (addrs 76798,76799), then done, error=0.
- Error: W=0 -> no fb_req ever; STATUS=0b110 two cycles after start. Also X0=320 -> same result.
- Backpressure: 1x3 fill at (0,0) with fb_gnt low for 3 cycles on pixel 1 -> fb_addr held at 1 and fb_data stable; exactly 3 writes total.
- Clear + controls: START_CLEAR|START_FILL with COLOR=0x00 -> 76800 writes, addrs 0..76799 ascending. Writes to X0 mid-command don't change output. IRQ_ACK in the completion cycle leaves irq=1; a later IRQ_ACK clears it.
- Reset mid-fill: assert rst after 5 grants of a 4x4 fill -> fb_req=0, busy=0, STATUS=0, all regs 0 next cycle; no further writes.
